// File: rtl/softex_tcdm_responder.sv
// rtl/softex_tcdm_responder.sv - TCDM memory-side responder for the softex streamer
//
// Serves hci_core req/gnt requests from an internal word array and returns exactly
// one response per granted request, in order, after LATENCY cycles (longer if the
// consumer back-pressures through r_ready).
//
// Ports:
//   clk_i, rst_ni, clear_i        clock, async active-low reset, sync soft clear
//   tcdm_req_i / tcdm_gnt_o       request handshake
//   tcdm_add_i                    byte address (word aligned, upper bits wrap)
//   tcdm_wen_i                    1 = read, 0 = write
//   tcdm_be_i, tcdm_data_i        write byte enables and data
//   tcdm_user_i                   user sideband, echoed on the response
//   tcdm_r_data_o, tcdm_r_user_o  response payload (r_data = 0 for writes)
//   tcdm_r_valid_o/tcdm_r_ready_i response handshake
//   outstanding_o                 responses granted and not yet popped
//   oob_o                         sticky out-of-range address flag
module softex_tcdm_responder #(
   parameter int          DATA_WIDTH      = 256,
   parameter int          ADDR_WIDTH      = 32,
   parameter int          UW              = 1,
   parameter int          MEM_WORDS       = 1024,
   parameter int          LATENCY         = 1,
   parameter int          RESP_FIFO_DEPTH = 4,
   parameter int          STALL_EN        = 0,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1,
   localparam int         CW              = $clog2(RESP_FIFO_DEPTH + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic                    tcdm_req_i,
   output logic                    tcdm_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
   input  logic                    tcdm_wen_i,
   input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
   input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
   input  logic [UW-1:0]           tcdm_user_i,
   output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
   output logic                    tcdm_r_valid_o,
   output logic [UW-1:0]           tcdm_r_user_o,
   input  logic                    tcdm_r_ready_i,
   output logic [CW-1:0]           outstanding_o,
   output logic                    oob_o
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam int OFF  = $clog2(BE_W);
   localparam int IW   = $clog2(MEM_WORDS);
   localparam int PW   = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;

   logic [15:0]                        lfsr;
   logic                               hs;
   logic                               pop;
   logic                               push;
   logic                               fifo_pop;
   logic                               fifo_empty;
   logic [IW-1:0]                      idx;
   logic [DATA_WIDTH-1:0]              mem [MEM_WORDS];
   logic [DATA_WIDTH-1:0]              rd_word;
   logic [DATA_WIDTH-1:0]              wr_word;
   logic [LATENCY-1:0]                 p_valid;
   logic [LATENCY-1:0][DATA_WIDTH-1:0] p_data;
   logic [LATENCY-1:0][UW-1:0]         p_user;
   logic                               out_valid;
   logic [DATA_WIDTH-1:0]              out_data;
   logic [UW-1:0]                      out_user;
   logic [DATA_WIDTH-1:0]              f_data [RESP_FIFO_DEPTH];
   logic [UW-1:0]                      f_user [RESP_FIFO_DEPTH];
   logic [PW-1:0]                      rptr;
   logic [PW-1:0]                      wptr;
   logic [CW-1:0]                      f_cnt;
   logic [CW-1:0]                      outstanding;
   logic                               oob;
   logic                               unused_addr_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RESP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Byte-offset bits are ignored: every access is word aligned.
   assign idx              = tcdm_add_i[OFF +: IW];
   assign unused_addr_bits = ^tcdm_add_i[OFF-1:0];

   // Credit check uses the registered count only, so a pop in the same cycle
   // cannot release a grant (no r_ready -> gnt path).
   assign tcdm_gnt_o = rst_ni & ~clear_i & tcdm_req_i
                     & (outstanding < CW'(RESP_FIFO_DEPTH))
                     & ((STALL_EN == 0) | lfsr[0]);
   assign hs = tcdm_req_i & tcdm_gnt_o;

   // Grant throttle: x^16+x^14+x^13+x^11, free running.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr <= LFSR_SEED;
      end else if (clear_i) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   // Word array: read returns the pre-write contents of the same edge.
   assign rd_word = mem[idx];

   always_comb begin
      wr_word = rd_word;
      for (int b = 0; b < BE_W; b++) begin
         if (tcdm_be_i[b]) begin
            wr_word[8*b +: 8] = tcdm_data_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (hs && !tcdm_wen_i) begin
         mem[idx] <= wr_word;
      end
   end

   // Fixed-latency pipeline; empty slots carry zero payload so r_data/r_user
   // read back as zero whenever nothing is valid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         p_valid <= '0;
         p_data  <= '0;
         p_user  <= '0;
      end else if (clear_i) begin
         p_valid <= '0;
         p_data  <= '0;
         p_user  <= '0;
      end else begin
         p_valid[0] <= hs;
         p_data[0]  <= (hs && tcdm_wen_i) ? rd_word : '0;
         p_user[0]  <= hs ? tcdm_user_i : '0;
         for (int s = 1; s < LATENCY; s++) begin
            p_valid[s] <= p_valid[s-1];
            p_data[s]  <= p_data[s-1];
            p_user[s]  <= p_user[s-1];
         end
      end
   end

   assign out_valid = p_valid[LATENCY-1];
   assign out_data  = p_data[LATENCY-1];
   assign out_user  = p_user[LATENCY-1];

   // Fall-through FIFO: when empty the pipeline output is presented directly and
   // is only stored if the consumer does not take it this cycle.
   assign fifo_empty     = (f_cnt == '0);
   assign tcdm_r_valid_o = ~fifo_empty | out_valid;
   assign tcdm_r_data_o  = fifo_empty ? out_data : f_data[rptr];
   assign tcdm_r_user_o  = fifo_empty ? out_user : f_user[rptr];
   assign pop            = tcdm_r_valid_o & tcdm_r_ready_i;
   assign fifo_pop       = pop & ~fifo_empty;
   assign push           = out_valid & ~(fifo_empty & tcdm_r_ready_i);

   always_ff @(posedge clk_i) begin
      if (push) begin
         f_data[wptr] <= out_data;
         f_user[wptr] <= out_user;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rptr        <= '0;
         wptr        <= '0;
         f_cnt       <= '0;
         outstanding <= '0;
         oob         <= 1'b0;
      end else if (clear_i) begin
         rptr        <= '0;
         wptr        <= '0;
         f_cnt       <= '0;
         outstanding <= '0;
         oob         <= 1'b0;
      end else begin
         if (push) begin
            wptr <= ptr_inc(wptr);
         end
         if (fifo_pop) begin
            rptr <= ptr_inc(rptr);
         end
         f_cnt       <= f_cnt + CW'(push) - CW'(fifo_pop);
         outstanding <= outstanding + CW'(hs) - CW'(pop);
         if (hs && (tcdm_add_i[ADDR_WIDTH-1:OFF+IW] != '0)) begin
            oob <= 1'b1;
         end
      end
   end

   assign outstanding_o = outstanding;
   assign oob_o         = oob;

endmodule

// File: tb/tb_softex_tcdm_responder.sv
// tb/tb_softex_tcdm_responder.sv - self-checking bench for softex_tcdm_responder
module tb_softex_tcdm_responder;

   localparam int DW    = 256;
   localparam int AW    = 32;
   localparam int UW    = 4;
   localparam int NW    = 1024;
   localparam int BEW   = DW / 8;
   localparam int DEPTH = 4;
   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   logic rst_n;
   logic clear;
   always #5 clk = ~clk;

   // Instance A: LATENCY=2, no throttling
   logic           a_req, a_gnt, a_wen, a_valid, a_ready, a_oob;
   logic [AW-1:0]  a_add;
   logic [BEW-1:0] a_be;
   logic [DW-1:0]  a_data, a_rdata;
   logic [UW-1:0]  a_user, a_ruser;
   logic [2:0]     a_out;

   // Instance B: LATENCY=1, LFSR throttled grant
   logic           b_req, b_gnt, b_wen, b_valid, b_ready, b_oob;
   logic [AW-1:0]  b_add;
   logic [BEW-1:0] b_be;
   logic [DW-1:0]  b_data, b_rdata;
   logic [UW-1:0]  b_user, b_ruser;
   logic [2:0]     b_out;

   softex_tcdm_responder #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .UW(UW), .MEM_WORDS(NW), .LATENCY(2),
      .RESP_FIFO_DEPTH(DEPTH), .STALL_EN(0), .LFSR_SEED(SEED)
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .tcdm_req_i(a_req), .tcdm_gnt_o(a_gnt), .tcdm_add_i(a_add), .tcdm_wen_i(a_wen),
      .tcdm_be_i(a_be), .tcdm_data_i(a_data), .tcdm_user_i(a_user),
      .tcdm_r_data_o(a_rdata), .tcdm_r_valid_o(a_valid), .tcdm_r_user_o(a_ruser),
      .tcdm_r_ready_i(a_ready), .outstanding_o(a_out), .oob_o(a_oob)
   );

   softex_tcdm_responder #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .UW(UW), .MEM_WORDS(NW), .LATENCY(1),
      .RESP_FIFO_DEPTH(DEPTH), .STALL_EN(1), .LFSR_SEED(SEED)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .tcdm_req_i(b_req), .tcdm_gnt_o(b_gnt), .tcdm_add_i(b_add), .tcdm_wen_i(b_wen),
      .tcdm_be_i(b_be), .tcdm_data_i(b_data), .tcdm_user_i(b_user),
      .tcdm_r_data_o(b_rdata), .tcdm_r_valid_o(b_valid), .tcdm_r_user_o(b_ruser),
      .tcdm_r_ready_i(b_ready), .outstanding_o(b_out), .oob_o(b_oob)
   );

   // Reference model: pending responses with the cycle they become visible.
   typedef struct {
      logic [DW-1:0] data;
      logic [UW-1:0] user;
      int            due;
   } resp_t;

   resp_t         qa[$];
   resp_t         qb[$];
   logic [DW-1:0] mem_a [NW];
   logic          oob_a;
   logic [15:0]   lfsr_b;
   int            now;
   int            vectors;
   int            miscompares;
   logic          a_granted, b_granted, rand_ready;
   logic [DW-1:0] a_last;
   int            a_pop_cnt, b_resp_cnt, b_grants;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom;
      return w;
   endfunction

   // One clock cycle: check outputs mid-cycle, then advance the model to the edge.
   task automatic step();
      logic eg, ev;
      resp_t r;
      int idx;
      if (rand_ready) a_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      // instance A
      eg = rst_n && !clear && a_req && (qa.size() < DEPTH);
      ev = (qa.size() > 0) && (qa[0].due <= now);
      chk("a_gnt", DW'(a_gnt), DW'(eg));
      chk("a_r_valid", DW'(a_valid), DW'(ev));
      chk("a_outstanding", DW'(a_out), DW'(qa.size()));
      chk("a_oob", DW'(a_oob), DW'(oob_a));
      a_granted = eg;
      if (ev && a_ready) begin
         chk("a_r_data", a_rdata, qa[0].data);
         chk("a_r_user", DW'(a_ruser), DW'(qa[0].user));
         a_last = qa[0].data;
         a_pop_cnt++;
         void'(qa.pop_front());
      end
      if (eg) begin
         idx    = int'(a_add[14:5]);
         r.data = a_wen ? mem_a[idx] : '0;
         r.user = a_user;
         r.due  = now + 2;
         qa.push_back(r);
         if (!a_wen)
            for (int b = 0; b < BEW; b++)
               if (a_be[b]) mem_a[idx][8*b +: 8] = a_data[8*b +: 8];
         if (a_add >= AW'(NW * BEW)) oob_a = 1'b1;
      end
      // instance B
      eg = rst_n && !clear && b_req && (qb.size() < DEPTH) && lfsr_b[0];
      ev = (qb.size() > 0) && (qb[0].due <= now);
      chk("b_gnt", DW'(b_gnt), DW'(eg));
      chk("b_r_valid", DW'(b_valid), DW'(ev));
      chk("b_outstanding", DW'(b_out), DW'(qb.size()));
      b_granted = eg;
      if (ev && b_ready) begin
         chk("b_r_data", b_rdata, '0);
         chk("b_r_user", DW'(b_ruser), DW'(qb[0].user));
         b_resp_cnt++;
         void'(qb.pop_front());
      end
      if (eg) begin
         r.data = '0;
         r.user = b_user;
         r.due  = now + 1;
         qb.push_back(r);
      end
      // reset / clear / LFSR
      if (!rst_n || clear) begin
         qa.delete();
         qb.delete();
         oob_a  = 1'b0;
         lfsr_b = SEED;
      end else begin
         lfsr_b = {lfsr_b[14:0], lfsr_b[15] ^ lfsr_b[13] ^ lfsr_b[12] ^ lfsr_b[10]};
      end
      @(posedge clk);
      #1;
      now++;
   endtask

   task automatic a_xfer(input logic wen, input logic [AW-1:0] add,
                         input logic [BEW-1:0] be, input logic [DW-1:0] data);
      int n;
      n      = 0;
      a_req  = 1'b1;
      a_wen  = wen;
      a_add  = add;
      a_be   = be;
      a_data = data;
      a_user = UW'($urandom);
      do begin
         step();
         n++;
      end while (!a_granted && n < 50);
      chk("a_xfer_granted", DW'(a_granted), DW'(1));
      a_req = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((qa.size() + qb.size()) > 0 && n < 100) begin
         step();
         n++;
      end
      chk("drain_empty", DW'(qa.size() + qb.size()), '0);
   endtask

   initial begin
      logic [DW-1:0] pat;
      logic [AW-1:0] ad;
      int n;

      vectors = 0; miscompares = 0; now = 0;
      a_pop_cnt = 0; b_resp_cnt = 0; b_grants = 0;
      oob_a = 1'b0; lfsr_b = SEED; rand_ready = 1'b0; a_last = '0;
      rst_n = 1'b0; clear = 1'b0;
      a_req = 1'b1; a_wen = 1'b1; a_add = '0; a_be = '0; a_data = '0; a_user = '0; a_ready = 1'b1;
      b_req = 1'b1; b_wen = 1'b0; b_add = '0; b_be = '0; b_data = '0; b_user = '0; b_ready = 1'b1;

      // reset: no grants while rst_n is low, outputs zero
      repeat (3) step();
      chk("rst_r_data", a_rdata, '0);
      chk("rst_r_user", DW'(a_ruser), '0);
      chk("rst_oob", DW'(a_oob), '0);
      chk("rst_outstanding", DW'(a_out), '0);
      a_req = 1'b0; b_req = 1'b0; rst_n = 1'b1;
      step();

      // full write then read back
      pat = {8{32'hDEADBEEF}};
      a_xfer(1'b0, 32'h40, '1, pat);
      a_xfer(1'b1, 32'h40, '0, '0);
      drain();
      chk("t1_read_back", a_last, pat);

      // byte-enable merge
      a_xfer(1'b0, 32'h80, '1, {32{8'h11}});
      a_xfer(1'b0, 32'h80, 32'h1, DW'(8'hFF));
      a_xfer(1'b1, 32'h80, '0, '0);
      drain();
      pat = {{31{8'h11}}, 8'hFF};
      chk("t2_byte_merge", a_last, pat);

      // random traffic over words 0..7 with random back-pressure and upper bits
      for (int i = 0; i < 8; i++) a_xfer(1'b0, AW'(i) << 5, '1, rand_word());
      rand_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         ad = (($urandom_range(0, 3) == 0) ? (AW'($urandom) << 15) : '0)
            | (AW'($urandom_range(0, 7)) << 5) | AW'($urandom_range(0, 31));
         a_xfer(1'($urandom_range(0, 1)), ad, BEW'($urandom), rand_word());
      end
      rand_ready = 1'b0;
      a_ready = 1'b1;
      drain();

      // back-pressure: 6 reads against a depth-4 FIFO
      a_ready = 1'b0;
      n = a_pop_cnt;
      for (int i = 0; i < 4; i++) a_xfer(1'b1, AW'(i) << 5, '0, '0);
      a_req = 1'b1; a_wen = 1'b1; a_add = AW'(4) << 5;
      repeat (3) step();
      chk("t3_outstanding_full", DW'(a_out), DW'(4));
      chk("t3_gnt_low", DW'(a_gnt), '0);
      a_ready = 1'b1;
      a_xfer(1'b1, AW'(4) << 5, '0, '0);
      a_xfer(1'b1, AW'(5) << 5, '0, '0);
      drain();
      chk("t3_resp_count", DW'(a_pop_cnt - n), DW'(6));

      // out-of-range read wraps and sets sticky oob
      clear = 1'b1; step(); clear = 1'b0;
      chk("t4_oob_cleared", DW'(a_oob), '0);
      a_xfer(1'b1, 32'hFFFF_0000, '0, '0);
      drain();
      chk("t4_oob_set", DW'(a_oob), DW'(1));
      chk("t4_wrapped_word", a_last, mem_a[0]);
      clear = 1'b1; step(); clear = 1'b0;
      chk("t4_oob_after_clear", DW'(a_oob), '0);

      // clear with 3 outstanding drops responses, keeps the write
      a_ready = 1'b0;
      pat = rand_word();
      a_xfer(1'b0, 32'h100, '1, pat);
      a_xfer(1'b1, 32'h0, '0, '0);
      a_xfer(1'b1, 32'h20, '0, '0);
      chk("t6_outstanding_3", DW'(a_out), DW'(3));
      clear = 1'b1; step(); clear = 1'b0;
      chk("t6_valid_dropped", DW'(a_valid), '0);
      chk("t6_outstanding_0", DW'(a_out), '0);
      a_ready = 1'b1;
      repeat (5) step();
      a_xfer(1'b1, 32'h100, '0, '0);
      drain();
      chk("t6_write_kept", a_last, pat);

      // throttled grants on instance B, 100 back-to-back writes
      n = 0;
      b_req = 1'b1; b_wen = 1'b0;
      b_add = $urandom; b_be = BEW'($urandom); b_data = rand_word(); b_user = UW'($urandom);
      while (b_grants < 100 && n < 2000) begin
         step();
         n++;
         if (b_granted) begin
            b_grants++;
            b_add = $urandom; b_be = BEW'($urandom); b_data = rand_word(); b_user = UW'($urandom);
         end
      end
      b_req = 1'b0;
      drain();
      chk("t5_grants", DW'(b_grants), DW'(100));
      chk("t5_responses", DW'(b_resp_cnt), DW'(100));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
